gf180mcu_cell_sweep_checker: RTL and testbench

- On-chip / bench-level truth-table checker for 2- to 4-input combinational library cells; default target is the aoi21 function.
- Drives an exhaustive input-vector sweep into the cell under test: upstream stage, feeding A1/A2/B.
- Samples the cell output after a programmable settle time and compares it to a parameterised golden truth table: downstream stage, consuming ZN.
- Reports pass/fail, error count and first failing vector. Used in library bring-up and characterisation harnesses.

---
 rtl/gf180mcu_cell_sweep_checker_pkg.sv | 32 +++
 rtl/gf180mcu_sweep_settle_timer.sv | 36 +++
 rtl/gf180mcu_cell_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_gf180mcu_cell_sweep_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_cell_sweep_checker_pkg.sv
// +----------------------------------------------------------------------------+
// | gf180mcu_cell_sweep_checker_pkg                                            |
// | Shared sweep-checker state encoding, golden cell truth tables and helpers. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package gf180mcu_cell_sweep_checker_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } sweep_state_e;

  // Vector bit0 is the first listed pin (A1), upward from there.
  localparam logic [3:0]  NAND2_TT = 4'h7;
  localparam logic [3:0]  NOR2_TT  = 4'h1;
  localparam logic [7:0]  AOI21_TT = 8'h07;
  localparam logic [7:0]  OAI21_TT = 8'h1F;
  localparam logic [15:0] AOI22_TT = 16'h0777;
  localparam logic [15:0] OAI22_TT = 16'h111F;

  // Error counter must hold the full vector count 2**n_in.
  function automatic int count_width(input int n_in);
    return n_in + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf180mcu_sweep_settle_timer.sv
// +----------------------------------------------------------------------------+
// | gf180mcu_sweep_settle_timer                                                |
// | Loadable up-counter; expire pulses on the last of SETTLE enabled cycles.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf180mcu_sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic CLK,
  input  logic RN,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [3:0] c_last = 4'(SETTLE - 1);

  logic [3:0] r_count;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + 4'd1;
    end
  end

  assign o_expire = i_en && (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/gf180mcu_cell_sweep_checker.sv
// +----------------------------------------------------------------------------+
// | gf180mcu_cell_sweep_checker                                                |
// | Exhaustive truth-table sweep checker for small combinational cells.        |
// | Option: GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN adds the ERR_MAP port.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module gf180mcu_cell_sweep_checker
  import gf180mcu_cell_sweep_checker_pkg::*;
#(
  parameter int                  N_IN   = 3,
  parameter logic [2**N_IN-1:0]  TRUTH  = AOI21_TT,
  parameter int                  SETTLE = 2
) (
  input  logic                            CLK,
  input  logic                            RN,
  input  logic                            START,
  output logic [N_IN-1:0]                 VEC,
  input  logic                            Z_IN,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            PASS,
  output logic [count_width(N_IN)-1:0]    ERR_CNT,
`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
  output logic [2**N_IN-1:0]              ERR_MAP,
`endif
  output logic [N_IN-1:0]                 FIRST_ERR_VEC
);

  localparam int              c_cnt_w    = count_width(N_IN);
  localparam logic [N_IN-1:0] c_last_vec = '1;

  sweep_state_e           r_state;
  sweep_state_e           w_next;
  logic                   w_load;
  logic                   w_start;
  logic                   w_expire;
  logic                   w_mismatch;
  logic [N_IN-1:0]        r_vec;
  logic [N_IN-1:0]        r_first_err;
  logic [c_cnt_w-1:0]     r_err_cnt;
  logic                   r_busy;
  logic                   r_done;

  gf180mcu_sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .CLK      (CLK),
    .RN       (RN),
    .i_load   (w_load),
    .i_en     (r_state == S_APPLY),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_start    = 1'b0;
    // Case inequality so an unknown cell output is scored as a failure.
    w_mismatch = (Z_IN !== TRUTH[r_vec]);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (START) begin
          w_next  = S_APPLY;
          w_load  = 1'b1;
          w_start = 1'b1;
        end
      end
      S_APPLY: begin
        if (w_expire) begin
          w_next = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (r_vec == c_last_vec) begin
          w_next = S_DONE;
        end else begin
          w_next = S_APPLY;
          w_load = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_vec       <= '0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy <= (w_next == S_APPLY) || (w_next == S_SAMPLE);
      r_done <= (w_next == S_DONE);
      if (w_start) begin
        r_vec       <= '0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
      end else if (r_state == S_SAMPLE) begin
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + 1'b1;
          if (r_err_cnt == '0) begin
            r_first_err <= r_vec;
          end
        end
        // Terminal vector is held through DONE rather than wrapping.
        if (r_vec != c_last_vec) begin
          r_vec <= r_vec + 1'b1;
        end
      end
    end
  end

`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
  logic [2**N_IN-1:0] r_err_map;

  always_ff @(posedge CLK) begin
    if (!RN) begin
      r_err_map <= '0;
    end else if (w_start) begin
      r_err_map <= '0;
    end else if ((r_state == S_SAMPLE) && w_mismatch) begin
      r_err_map[r_vec] <= 1'b1;
    end
  end

  assign ERR_MAP = r_err_map;
`endif

  assign VEC           = r_vec;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign ERR_CNT       = r_err_cnt;
  assign FIRST_ERR_VEC = r_first_err;
  assign PASS          = (r_state == S_DONE) && (r_err_cnt == '0);

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_cell_sweep_checker.sv
// +----------------------------------------------------------------------------+
// | tb_gf180mcu_cell_sweep_checker                                             |
// | Randomised sweeps of a modelled cell against a timeline reference model.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_gf180mcu_cell_sweep_checker;

  localparam int N  = 3;
  localparam int S  = 2;
  localparam int P  = S + 1;
  localparam int NV = 1 << N;
  localparam int L  = NV * P;

  logic          CLK   = 1'b0;
  logic          RN    = 1'b0;
  logic          START = 1'b0;
  logic          Z_IN  = 1'b0;
  logic [N-1:0]  VEC;
  logic          BUSY;
  logic          DONE;
  logic          PASS;
  logic [N:0]    ERR_CNT;
  logic [N-1:0]  FIRST_ERR_VEC;
`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
  logic [NV-1:0] ERR_MAP;
`endif

  gf180mcu_cell_sweep_checker #(
    .N_IN   (N),
    .TRUTH  (8'h07),
    .SETTLE (S)
  ) dut (
    .CLK           (CLK),
    .RN            (RN),
    .START         (START),
    .VEC           (VEC),
    .Z_IN          (Z_IN),
    .BUSY          (BUSY),
    .DONE          (DONE),
    .PASS          (PASS),
    .ERR_CNT       (ERR_CNT),
`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
    .ERR_MAP       (ERR_MAP),
`endif
    .FIRST_ERR_VEC (FIRST_ERR_VEC)
  );

  always #5 CLK = ~CLK;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [NV-1:0] gold_tt;
  // Model: m_on = a sweep has been started since reset; m_t = cycles since
  // its first APPLY cycle; m_tt = behaviour of the modelled cell.
  bit            m_on = 1'b0;
  int            m_t  = 0;
  logic [NV-1:0] m_tt = '0;
  logic [NV-1:0] next_tt = '0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", name, act, exp, m_t);
    end
  endtask

  task automatic check_all();
    int            ev, ee, ef, eb, ed;
    logic [NV-1:0] em;
    ev = 0; ee = 0; ef = 0; eb = 0; ed = 0; em = '0;
    if (m_on) begin
      eb = (m_t < L) ? 1 : 0;
      ed = 1 - eb;
      ev = eb ? (m_t / P) : (NV - 1);
      for (int v = 0; v < NV; v++) begin
        if ((v * P + S) < m_t && m_tt[v] !== gold_tt[v]) begin
          if (ee == 0) ef = v;
          ee++;
          em[v] = 1'b1;
        end
      end
    end
    chk("busy", int'(BUSY), eb);
    chk("done", int'(DONE), ed);
    chk("vec", int'(VEC), ev);
    chk("err_cnt", int'(ERR_CNT), ee);
    chk("first_err", int'(FIRST_ERR_VEC), ef);
    chk("pass", int'(PASS), (ed == 1 && ee == 0) ? 1 : 0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
    chk("err_map", int'(ERR_MAP), int'(em));
`endif
  endtask

  // One clock: advance the model across the edge, check, then present the
  // cell output. Non-sample cycles get random noise on Z_IN.
  task automatic step();
    @(posedge CLK);
    if (!RN) begin
      m_on = 1'b0;
    end else if (START && (!m_on || m_t >= L)) begin
      m_on = 1'b1;
      m_t  = 0;
      m_tt = next_tt;
    end else if (m_on) begin
      m_t++;
    end
    @(negedge CLK);
    check_all();
    if (m_on && m_t < L && (m_t % P) == S)
      Z_IN = m_tt[m_t / P];
    else
      Z_IN = 1'($urandom_range(0, 1));
  endtask

  task automatic sweep(input logic [NV-1:0] tt);
    next_tt = tt;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (L + 1) step();
  endtask

  initial begin
    gold_tt = 8'h07;
    RN = 1'b0;
    repeat (3) step();
    RN = 1'b1;
    repeat (2) step();

    // Ideal aoi21 cell.
    sweep(8'h07);
    chk("ideal_err", int'(ERR_CNT), 0);
    chk("ideal_pass", int'(PASS), 1);
    chk("ideal_vec", int'(VEC), 7);

    // Output stuck at 1; restart straight from DONE.
    sweep(8'hFF);
    chk("hi_err", int'(ERR_CNT), 5);
    chk("hi_first", int'(FIRST_ERR_VEC), 3);
    chk("hi_pass", int'(PASS), 0);
`ifdef GF180MCU_FD_SC_MCU9T5V0__SWEEP_ERRMAP_EN
    chk("hi_map", int'(ERR_MAP), 8'hF8);
`endif

    // Output stuck at 0, START held as a level for the first 10 cycles.
    next_tt = 8'h00;
    START = 1'b1;
    repeat (10) step();
    START = 1'b0;
    repeat (L) step();
    chk("lo_err", int'(ERR_CNT), 3);
    chk("lo_first", int'(FIRST_ERR_VEC), 0);
    chk("lo_pass", int'(PASS), 0);

    // Stray START pulse at cycle 5 must not disturb the sweep.
    next_tt = 8'hFF;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (5) step();
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (L - 5) step();
    chk("stray_err", int'(ERR_CNT), 5);
    chk("stray_done", int'(DONE), 1);

    // Reset at cycle 10 of a sweep, then a complete fresh sweep.
    next_tt = 8'hFF;
    START = 1'b1;
    step();
    START = 1'b0;
    repeat (10) step();
    RN = 1'b0;
    step();
    RN = 1'b1;
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_vec", int'(VEC), 0);
    chk("rst_err", int'(ERR_CNT), 0);
    sweep(NV'($urandom));

    // Random cells with random stray STARTs and occasional resets.
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 3)) step();
      next_tt = NV'($urandom);
      START = 1'b1;
      step();
      START = 1'b0;
      for (int c = 0; c < L + 2; c++) begin
        START = ($urandom_range(0, 7) == 0 && m_t < L - 1) ? 1'b1 : 1'b0;
        RN    = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
        step();
      end
      START = 1'b0;
      RN = 1'b1;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
